seq_match_ctrl: RTL

- Run controller for serial pattern detection on a 1-bit stream.
- Software loads a pattern of 1..MAX_LEN bits, a match target and a timeout, then pulses start.
- The block hunts the stream with a Mealy-style detector, counts matches, and terminates on target reached, timeout, or abort.
- Sits between the control registers and the serial input, replacing fixed per-pattern detectors with one configurable, sequenced resource.

---
 rtl/seq_match_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_match_ctrl.sv
// Configurable serial pattern-match run controller: IDLE -> HUNT -> DONE with target/timeout/abort.
// Optional macro SEQ_NONOVERLAP_EN: a counted match restarts detection (non-overlapping matches).
module seq_match_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               timed_out
);

    typedef enum logic [1:0] {IDLE, HUNT, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t             state, state_nx;
    logic [MAX_LEN-1:0] pat_q, hist, mask, window;
    logic [LEN_W-1:0]   len_q, fill;
    logic [CNT_W-1:0]   tgt_q;
    logic [TO_W-1:0]    to_q, timer;
    logic               len_ok, cnt_inc, hit, tmo, fill_ok;

    assign len_ok = (cfg_len != '0) && (cfg_len <= MAX_L);
    assign window = {hist[MAX_LEN-2:0], bit_in};
    assign fill_ok = fill >= (len_q - LEN_W'(1));

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = LEN_W'(i) < len_q;
    end

    assign match   = (state == HUNT) && bit_valid && fill_ok && (((window ^ pat_q) & mask) == '0);
    assign cnt_inc = match && !abort;
    // Extended by one bit so a saturated counter never aliases onto the target.
    assign hit     = cnt_inc && (tgt_q != '0) &&
                     (({1'b0, match_cnt} + (CNT_W+1)'(1)) == {1'b0, tgt_q});
    assign tmo     = (to_q != '0) && (timer == to_q - TO_W'(1));

    assign busy = (state == HUNT);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start && len_ok) state_nx = HUNT;
                HUNT:       if (hit || tmo) state_nx = DONE;
                default:    state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            tgt_q     <= '0;
            to_q      <= '0;
            hist      <= '0;
            fill      <= '0;
            timer     <= '0;
            match_cnt <= '0;
            timed_out <= 1'b0;
        end else begin
            state <= state_nx;
            if (abort) begin
                timed_out <= 1'b0;
            end else if (state != HUNT && start && len_ok) begin
                pat_q     <= cfg_pattern;
                len_q     <= cfg_len;
                tgt_q     <= cfg_target;
                to_q      <= cfg_timeout;
                hist      <= '0;
                fill      <= '0;
                timer     <= '0;
                match_cnt <= '0;
                timed_out <= 1'b0;
            end else if (state == HUNT) begin
                timer <= timer + TO_W'(1);
                if (bit_valid) begin
                    hist <= window;
                    if (fill != MAX_L) fill <= fill + LEN_W'(1);
                end
                if (cnt_inc) begin
                    if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
`ifdef SEQ_NONOVERLAP_EN
                    hist <= '0;
                    fill <= '0;
`else
`endif
                end
                // A completing match beats a timeout landing on the same cycle.
                if (hit)      timed_out <= 1'b0;
                else if (tmo) timed_out <= 1'b1;
            end
        end
    end

endmodule
